mod_inv_engine: RTL
===================

# mod_inv_engine

Sequential modular-inversion engine computing `res = a^-1 mod p` with the binary extended Euclidean algorithm over an odd prime `p`. It drives one reduction operation per clock on internal registers: halving with the conditional `+p` correction, or a subtraction. It sits between the point-arithmetic controller and the projective-to-affine conversion. It accepts one operand per start pulse and returns the registered inverse with a done pulse.

## Interface
- `WIDTH`, 256, operand and modulus width in bits.
- `MAX_CYCLES`, 1100, loop-cycle bound. Used only when the watchdog is compiled in.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `a`  in  WIDTH  operand; valid range 1..p-1; sampled with `start`.
- `p`  in  WIDTH  odd prime modulus; sampled with `start`.
- `busy`  out  1  high while a computation is in progress.
- `done`  out  1  one-cycle pulse when `res`/`err` are valid.
- `res`  out  WIDTH  inverse in [0,p-1]; held until the next `done`.
- `err`  out  1  high with `done` when no result is produced; held with `res`.

## Operation
- Registers: `u`, `v`, `x1`, `x2` (WIDTH each) and a latched `p`.
- States: IDLE, LOOP, DONE.
- IDLE + `start`:
  - If `a==0` or `a>=p`: go to DONE with `err=1`, `res=0`.
  - Otherwise load `u=a`, `v=p`, `x1=1`, `x2=0`, then go to LOOP.
- IDLE without `start`: no action.
- LOOP performs exactly one action per cycle, chosen by priority:
  - `u==1`: `res<=x1`, go to DONE.
  - else `v==1`: `res<=x2`, go to DONE.
  - else `u` even: `u<=u>>1`. `x1<=x1>>1` if `x1` is even, otherwise `x1<=(x1+p)>>1`, with the sum formed in WIDTH+1 bits.
  - else `v` even: same halving on `v` and `x2`.
  - else `u>=v`: `u<=u-v`, `x1<=(x1-x2) mod p`.
  - else: `v<=v-u`, `x2<=(x2-x1) mod p`.
- Modular subtraction: compute the difference in WIDTH+1 bits; on borrow, add `p`. `x1` and `x2` therefore always stay in [0,p-1].
- DONE: assert `done` for one cycle, then return to IDLE.
- `start` while `busy` is ignored and has no side effects.
- `a` and `p` may change after the start cycle without affecting the computation.

## Timing
- Reset values: `busy=0`, `done=0`, `err=0`, `res=0`, state IDLE, all internal registers 0.
- `start` sampled at edge E0:
  - `busy` is high from E0 until the edge that enters DONE.
  - `done` is high for the cycle after the terminating LOOP edge.
- Latency:
  - `a==1`: `done` in the second cycle after the start edge (E0 load, E1 detect, done after E1).
  - `a==0` or `a>=p`: `done` in the cycle after E0.
  - Worst case for WIDTH=256: at most 2·WIDTH+2 LOOP cycles.
- `start` can be accepted again in the cycle `done` is high, since the state is DONE→IDLE. New `start` is sampled at the edge leaving DONE.
- Reset mid-operation: immediate return to IDLE. `done` is not asserted and `res` is cleared.

## Configuration
- `MOD_INV_WATCHDOG_EN` defined:
  - An 11-bit LOOP cycle counter is included.
  - If the counter reaches `MAX_CYCLES` without terminating, go to DONE with `err=1`, `res=0`.
  - This covers non-prime or even `p` supplied by software.
- Not defined: no counter. Termination relies on valid `p`; an even `p` gives undefined latency.

## Structure
- Package `mod_inv_pkg` holds:
  - the `WIDTH` default constant;
  - the state enum (IDLE, LOOP, DONE);
  - the `MAX_CYCLES` default.
- Sub-module `mod_sub`: combinational `(a-b) mod p` on WIDTH+1-bit arithmetic. It is instantiated once and muxed between `x1-x2` and `x2-x1`.
- The halving path is inline in LOOP.

## Test plan
- `p=23`, `a=3` → `res=8`, `err=0`. Check `3·8 mod 23 = 1`.
- `p=23`, `a=1` → `res=1`, `done` in the second cycle after start. Also `a=22` → `res=22`.
- `p=23`, `a=0` → `done` in the next cycle, `err=1`, `res=0`. Also `a=23` → same.
- `p=2^255-19`, `a=2` → `res=(p+1)/2`. Check that LOOP cycle count ≤ 514.
- Pulse `start` mid-computation with a different `a` → ignored, original result returned. Then assert `rst_n=0` during a later run → `busy`, `done`, `res` all 0 and no `done` pulse.
- With `MOD_INV_WATCHDOG_EN` and `MAX_CYCLES=4`: `p=2^255-19`, `a=3` → `err=1`, `res=0` after 4 LOOP cycles.

Source files
------------

// File: rtl/mod_inv_pkg.sv
// ============================================================================
// Module   : mod_inv_pkg
// Brief    : Shared defaults and FSM encoding for the modular-inversion engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mod_inv_pkg;

    localparam int C_WIDTH      = 256;
    localparam int C_MAX_CYCLES = 1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOOP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : mod_inv_pkg

`default_nettype wire

// File: rtl/mod_sub.sv
// ============================================================================
// Module   : mod_sub
// Brief    : Combinational (a - b) mod p for a, b already reduced into [0,p-1].
// Revision : 1.0
// ============================================================================
`default_nettype none

module mod_sub #(
    parameter int WIDTH = 256
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_p,
    output logic [WIDTH-1:0] o_diff
);

    logic [WIDTH:0] w_diff;

    // Top bit of the extended difference is the borrow; adding p folds it back.
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};
    assign o_diff = w_diff[WIDTH] ? (w_diff[WIDTH-1:0] + i_p) : w_diff[WIDTH-1:0];

endmodule : mod_sub

`default_nettype wire

// File: rtl/mod_inv_engine.sv
// ============================================================================
// Module   : mod_inv_engine
// Brief    : Binary extended-Euclid modular inverse, one reduction per clock.
//            Optional loop watchdog: define MOD_INV_WATCHDOG_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mod_inv_engine
    import mod_inv_pkg::*;
#(
    parameter int WIDTH      = C_WIDTH,
    parameter int MAX_CYCLES = C_MAX_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] p,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             err
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_u, r_v, r_x1, r_x2, r_p, r_res;
    logic [WIDTH-1:0] w_u_nxt, w_v_nxt, w_x1_nxt, w_x2_nxt, w_p_nxt, w_res_nxt;
    logic             r_err, w_err_nxt;
    logic             w_load;

    logic             w_u_one, w_v_one, w_u_ge_v, w_a_bad, w_wd_expire;
    logic [WIDTH:0]   w_x1_psum, w_x2_psum;
    logic [WIDTH-1:0] w_x1_half, w_x2_half;
    logic [WIDTH-1:0] w_sub_a, w_sub_b, w_sub_diff;

    assign w_u_one  = (r_u == c_one);
    assign w_v_one  = (r_v == c_one);
    assign w_u_ge_v = (r_u >= r_v);
    assign w_a_bad  = (a == '0) || (a >= p);

    // Odd coefficients get +p before halving so the shift stays exact mod p.
    assign w_x1_psum = {1'b0, r_x1} + {1'b0, r_p};
    assign w_x2_psum = {1'b0, r_x2} + {1'b0, r_p};
    assign w_x1_half = r_x1[0] ? w_x1_psum[WIDTH:1] : {1'b0, r_x1[WIDTH-1:1]};
    assign w_x2_half = r_x2[0] ? w_x2_psum[WIDTH:1] : {1'b0, r_x2[WIDTH-1:1]};

    assign w_sub_a = w_u_ge_v ? r_x1 : r_x2;
    assign w_sub_b = w_u_ge_v ? r_x2 : r_x1;

    mod_sub #(
        .WIDTH (WIDTH)
    ) u_mod_sub (
        .i_a    (w_sub_a),
        .i_b    (w_sub_b),
        .i_p    (r_p),
        .o_diff (w_sub_diff)
    );

`ifdef MOD_INV_WATCHDOG_EN
    localparam logic [10:0] c_max_cycles = 11'(MAX_CYCLES);

    logic [10:0] r_cycles;

    // Expires on the MAX_CYCLES-th LOOP cycle, so exactly MAX_CYCLES are spent.
    assign w_wd_expire = (r_cycles == (c_max_cycles - 11'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycles <= '0;
        end else if (w_load) begin
            r_cycles <= '0;
        end else if (r_state == ST_LOOP) begin
            r_cycles <= r_cycles + 11'd1;
        end
    end
`else
    localparam int c_unused_max_cycles = MAX_CYCLES;

    assign w_wd_expire = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_u_nxt     = r_u;
        w_v_nxt     = r_v;
        w_x1_nxt    = r_x1;
        w_x2_nxt    = r_x2;
        w_p_nxt     = r_p;
        w_res_nxt   = r_res;
        w_err_nxt   = r_err;
        w_load      = 1'b0;

        case (r_state)
            // DONE behaves like IDLE for start so back-to-back requests lose no cycle.
            ST_IDLE, ST_DONE: begin
                w_state_nxt = ST_IDLE;
                if (start) begin
                    if (w_a_bad) begin
                        w_state_nxt = ST_DONE;
                        w_res_nxt   = '0;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = ST_LOOP;
                        w_load      = 1'b1;
                        w_u_nxt     = a;
                        w_v_nxt     = p;
                        w_x1_nxt    = c_one;
                        w_x2_nxt    = '0;
                        w_p_nxt     = p;
                    end
                end
            end

            ST_LOOP: begin
                if (w_u_one) begin
                    w_state_nxt = ST_DONE;
                    w_res_nxt   = r_x1;
                    w_err_nxt   = 1'b0;
                end else if (w_v_one) begin
                    w_state_nxt = ST_DONE;
                    w_res_nxt   = r_x2;
                    w_err_nxt   = 1'b0;
                end else if (w_wd_expire) begin
                    w_state_nxt = ST_DONE;
                    w_res_nxt   = '0;
                    w_err_nxt   = 1'b1;
                end else if (!r_u[0]) begin
                    w_u_nxt  = {1'b0, r_u[WIDTH-1:1]};
                    w_x1_nxt = w_x1_half;
                end else if (!r_v[0]) begin
                    w_v_nxt  = {1'b0, r_v[WIDTH-1:1]};
                    w_x2_nxt = w_x2_half;
                end else if (w_u_ge_v) begin
                    w_u_nxt  = r_u - r_v;
                    w_x1_nxt = w_sub_diff;
                end else begin
                    w_v_nxt  = r_v - r_u;
                    w_x2_nxt = w_sub_diff;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_u   <= '0;
            r_v   <= '0;
            r_x1  <= '0;
            r_x2  <= '0;
            r_p   <= '0;
            r_res <= '0;
            r_err <= 1'b0;
        end else begin
            r_u   <= w_u_nxt;
            r_v   <= w_v_nxt;
            r_x1  <= w_x1_nxt;
            r_x2  <= w_x2_nxt;
            r_p   <= w_p_nxt;
            r_res <= w_res_nxt;
            r_err <= w_err_nxt;
        end
    end

    assign busy = (r_state == ST_LOOP);
    assign done = (r_state == ST_DONE);
    assign res  = r_res;
    assign err  = r_err;

endmodule : mod_inv_engine

`default_nettype wire
